// File: rtl/latch_input_conditioner.sv
// latch_input_conditioner
//
// Front end for the lab-board NAND-gate D latch. It synchronizes and
// debounces a raw data switch and a raw enable button. Each accepted press
// becomes one fixed-width enable pulse, and the data value is frozen for
// the whole of that pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  clocks an input must disagree with its debounced level
//                    before that level flips (>= 1)
//   EN_PULSE_CYCLES  width of E in clocks per accepted press (>= 1)
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   sw_d         raw data switch, asynchronous to clk
//   btn_e        raw enable button, asynchronous to clk, active-high
//   D            registered data to the latch
//   E            registered enable pulse to the latch
//   btn_level    debounced button level
//   press_count  accepted presses, modulo 256

// Two-flop synchronizer followed by a counting debouncer. The debounced
// level flips once the synchronized input has disagreed with it for
// CYCLES consecutive clocks; any agreement clears the count.
module latch_input_conditioner_debounce #(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values; blocking here would collapse the
    // two synchronizer stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // The flip happens on the edge where the count would reach CYCLES, so
    // the level changes CYCLES clocks after the synchronized value does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync_q[1];
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module latch_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EN_PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_d,
    input  logic       btn_e,
    output logic       D,
    output logic       E,
    output logic       btn_level,
    output logic [7:0] press_count
);
    localparam int PC_W = $clog2(EN_PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_RELEASE
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pulse_cnt, pulse_cnt_next;
    logic            sw_level;
    logic            btn_prev;
    logic            btn_rise;

    latch_input_conditioner_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_e),
        .level (btn_level)
    );

    latch_input_conditioner_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_d),
        .level (sw_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_level;
        end
    end

    assign btn_rise = btn_level & ~btn_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pulse_cnt <= '0;
        end else begin
            state     <= state_next;
            pulse_cnt <= pulse_cnt_next;
        end
    end

    // NOTE: every always_comb output is given a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        pulse_cnt_next = pulse_cnt;
        case (state)
            IDLE: begin
                if (btn_rise) begin
                    state_next     = PULSE;
                    pulse_cnt_next = '0;
                end
            end
            PULSE: begin
                // The pulse counter marks the clocks already spent in PULSE;
                // on the last one the FSM moves on.
                if (pulse_cnt == PC_W'(EN_PULSE_CYCLES - 1)) begin
                    state_next     = WAIT_RELEASE;
                    pulse_cnt_next = '0;
                end else begin
                    pulse_cnt_next = pulse_cnt + PC_W'(1);
                end
            end
            WAIT_RELEASE: begin
                // A rising edge cannot coincide with leaving this state,
                // since leaving requires the debounced button to be low.
                if (!btn_level) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered so E is glitch-free at the latch. E tracks the
    // next state so it is high exactly while the FSM sits in PULSE. D
    // follows the debounced switch except while in PULSE, so the value
    // captured on the IDLE->PULSE edge is held for the whole pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D           <= 1'b0;
            E           <= 1'b0;
            press_count <= '0;
        end else begin
            E <= (state_next == PULSE);
            if (state != PULSE) begin
                D <= sw_level;
            end
            if (state == IDLE && btn_rise) begin
                press_count <= press_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_latch_input_conditioner.sv
// Directed testbench for latch_input_conditioner with DEBOUNCE_CYCLES=4 and
// EN_PULSE_CYCLES=3. Edge k is the k-th rising edge after an input change
// is driven (edge 0 samples it). Outputs are sampled 1 ns after each edge.
module tb_latch_input_conditioner;
    localparam int N = 4;
    localparam int P = 3;

    logic       clk;
    logic       rst;
    logic       sw_d;
    logic       btn_e;
    logic       d;
    logic       e;
    logic       btn_level;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_pass   = 0;

    latch_input_conditioner #(
        .DEBOUNCE_CYCLES (N),
        .EN_PULSE_CYCLES (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_d        (sw_d),
        .btn_e       (btn_e),
        .D           (d),
        .E           (e),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        sw_d  = 1'b0;
        btn_e = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    int pulses;
    logic e_prev;

    initial begin
        rst   = 1'b1;
        sw_d  = 1'b0;
        btn_e = 1'b0;
        #1;
        check("reset_D", d, 0);
        check("reset_E", e, 0);
        check("reset_btn_level", btn_level, 0);
        check("reset_press_count", press_count, 0);
        do_reset();

        // Clean press held 20 clocks: level after edge 5, E on edges 6..8.
        pulses = 0;
        e_prev = 1'b0;
        btn_e  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("clean_btn_level_e%0d", k), btn_level, (k >= 5) ? 1 : 0);
            check($sformatf("clean_E_e%0d", k), e, (k >= 6 && k <= 8) ? 1 : 0);
            check($sformatf("clean_count_e%0d", k), press_count, (k >= 6) ? 1 : 0);
            if (e && !e_prev) pulses++;
            e_prev = e;
        end
        check("clean_single_pulse", pulses, 1);
        btn_e = 1'b0;
        ticks(12);
        check("clean_released_level", btn_level, 0);
        check("clean_released_count", press_count, 1);

        // Bounce: 1,0,1,0 on successive clocks then 0 -> nothing happens.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            btn_e = (k % 2 == 0);
            tick();
        end
        btn_e = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("bounce_level_%0d", k), btn_level, 0);
            check($sformatf("bounce_E_%0d", k), e, 0);
        end
        check("bounce_count", press_count, 0);

        // Switch glitch of N-1 clocks is filtered; a change of N clocks
        // reaches D after edge 2+N.
        do_reset();
        sw_d = 1'b1;
        ticks(N - 1);
        sw_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("sw_glitch_D_%0d", k), d, 0);
        end
        sw_d = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("sw_change_D_e%0d", k), d, (k >= 6) ? 1 : 0);
        end

        // D freeze: switch dropped at edge 2 of the press would reach D
        // after edge 8, but PULSE holds it until edge 10.
        do_reset();
        sw_d = 1'b1;
        ticks(10);
        check("freeze_D_before", d, 1);
        btn_e = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k == 1) sw_d = 1'b0;
            check($sformatf("freeze_D_e%0d", k), d, (k < 10) ? 1 : 0);
            check($sformatf("freeze_E_e%0d", k), e, (k >= 6 && k <= 8) ? 1 : 0);
        end
        btn_e = 1'b0;
        ticks(12);

        // Short press: raw high for edges 0..5 only. Full pulse, level falls
        // after edge 11, then a second press counts to 2.
        do_reset();
        btn_e = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 5) btn_e = 1'b0;
            check($sformatf("short_E_e%0d", k), e, (k >= 6 && k <= 8) ? 1 : 0);
            check($sformatf("short_level_e%0d", k), btn_level, (k >= 5 && k <= 10) ? 1 : 0);
        end
        btn_e = 1'b1;
        ticks(7);
        check("short_second_E", e, 1);
        check("short_second_count", press_count, 2);
        btn_e = 1'b0;
        ticks(12);

        // Wrap: 256 clean presses.
        do_reset();
        pulses = 0;
        e_prev = 1'b0;
        for (int p = 0; p < 256; p++) begin
            btn_e = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (e && !e_prev) pulses++;
                e_prev = e;
            end
            btn_e = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (e && !e_prev) pulses++;
                e_prev = e;
            end
            if (p == 254) check("wrap_count_255", press_count, 255);
        end
        check("wrap_count_0", press_count, 0);
        check("wrap_pulses", pulses, 256);

        // Async reset mid-pulse with the button still held.
        do_reset();
        sw_d  = 1'b1;
        btn_e = 1'b1;
        ticks(8);
        check("areset_pre_E", e, 1);
        check("areset_pre_D", d, 1);
        check("areset_pre_count", press_count, 1);
        #3;
        rst = 1'b1;
        #1;
        check("areset_E", e, 0);
        check("areset_D", d, 0);
        check("areset_count", press_count, 0);
        check("areset_level", btn_level, 0);
        ticks(2);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("areset_level_e%0d", k), btn_level, (k >= 5) ? 1 : 0);
            check($sformatf("areset_E_e%0d", k), e, (k >= 6) ? 1 : 0);
        end
        check("areset_count_after", press_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
